// File: rtl/edge_scan_ctrl_if.sv
// Handshake/bus bundle for edge_scan_ctrl.
// Optional EDGE_SCAN_COUNT_EN adds the edgeCount signal to the bundle.
interface edge_scan_ctrl_if;
  logic        start;
  logic [24:0] adjFlat;
  logic        pairReady;
  logic        pairValid;
  logic [2:0]  pairI;
  logic [2:0]  pairJ;
  logic        busy;
  logic        done;
`ifdef EDGE_SCAN_COUNT_EN
  logic [3:0]  edgeCount;

  modport master (
    output start, adjFlat, pairReady,
    input  pairValid, pairI, pairJ, busy, done, edgeCount
  );
  modport slave (
    input  start, adjFlat, pairReady,
    output pairValid, pairI, pairJ, busy, done, edgeCount
  );
`else
  modport master (
    output start, adjFlat, pairReady,
    input  pairValid, pairI, pairJ, busy, done
  );
  modport slave (
    input  start, adjFlat, pairReady,
    output pairValid, pairI, pairJ, busy, done
  );
`endif
endinterface

// File: rtl/edge_scan_ctrl.sv
// edge_scan_ctrl: walks the upper triangle of a captured 5x5 adjacency matrix
// and emits each present edge (i<j) over a valid/ready handshake.
// Optional macro EDGE_SCAN_COUNT_EN adds a saturating accepted-pair counter.
module edge_scan_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  edge_scan_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StEmit = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [24:0] adj_q, adj_d;
  logic [2:0]  cur_i_q, cur_i_d, cur_j_q, cur_j_d;
  logic [2:0]  pair_i_q, pair_i_d, pair_j_q, pair_j_d;
  logic        pair_valid_q, pair_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [2:0]  nxt_i, nxt_j;
  logic        cur_last;
  logic [4:0]  bit_idx;

  assign cur_last = (cur_i_q == 3'd3) && (cur_j_q == 3'd4);
  assign bit_idx  = {2'b00, cur_i_q} * 5'd5 + {2'b00, cur_j_q};

  // Next upper-triangle cursor position in row-major order.
  always_comb begin
    if (cur_j_q == 3'd4) begin
      nxt_i = cur_i_q + 3'd1;
      nxt_j = cur_i_q + 3'd2;
    end else begin
      nxt_i = cur_i_q;
      nxt_j = cur_j_q + 3'd1;
    end
  end

  // FSM next-state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    adj_d        = adj_q;
    cur_i_d      = cur_i_q;
    cur_j_d      = cur_j_q;
    pair_i_d     = pair_i_q;
    pair_j_d     = pair_j_q;
    pair_valid_d = pair_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          adj_d   = bus.adjFlat;
          cur_i_d = 3'd0;
          cur_j_d = 3'd1;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (adj_q[bit_idx]) begin
          pair_i_d     = cur_i_q;
          pair_j_d     = cur_j_q;
          pair_valid_d = 1'b1;
          state_d      = StEmit;
        end else if (cur_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cur_i_d = nxt_i;
          cur_j_d = nxt_j;
        end
      end
      StEmit: begin
        if (bus.pairReady) begin
          pair_valid_d = 1'b0;
          // Cannot exceed 10 in practice; the guard keeps it from wrapping.
          if (cnt_q != 4'd10) cnt_d = cnt_q + 4'd1;
          if (cur_last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            cur_i_d = nxt_i;
            cur_j_d = nxt_j;
            state_d = StScan;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset also drops any pending pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      adj_q        <= '0;
      cur_i_q      <= 3'd0;
      cur_j_q      <= 3'd1;
      pair_i_q     <= 3'd0;
      pair_j_q     <= 3'd0;
      pair_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      adj_q        <= adj_d;
      cur_i_q      <= cur_i_d;
      cur_j_q      <= cur_j_d;
      pair_i_q     <= pair_i_d;
      pair_j_q     <= pair_j_d;
      pair_valid_q <= pair_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.pairValid = pair_valid_q;
  assign bus.pairI     = pair_i_q;
  assign bus.pairJ     = pair_j_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef EDGE_SCAN_COUNT_EN
  assign bus.edgeCount = cnt_q;
`else
  // Counter logic is left unobserved and is trimmed by synthesis.
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Scoreboard bench for edge_scan_ctrl: the stimulus side pushes the expected
// pair list (from a plain upper-triangle model), the monitor pops and checks.
module tb_edge_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  edge_scan_ctrl_if bus ();

  edge_scan_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_npairs = 0;
  int stalls = 0;
  int rdy_mode = 0;
  int hold_left = 0;
  bit mon_en = 1'b0;
  logic [5:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] upper_mask();
    logic [24:0] m = '0;
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++) m[i*5+j] = 1'b1;
    return m;
  endfunction

  // Ready driver: 0 always ready, 1 random, 2 low for hold_left valid cycles, 3 never.
  initial begin
    bus.pairReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.pairReady = 1'b1;
        1: bus.pairReady = ($urandom_range(0, 3) != 0);
        2: begin
          if (bus.pairValid && hold_left > 0) begin
            bus.pairReady = 1'b0;
            hold_left--;
          end else begin
            bus.pairReady = 1'b1;
          end
        end
        default: bus.pairReady = 1'b0;
      endcase
    end
  end

  // Monitor: pair order/content, hold stability, done timing.
  initial begin
    bit         prev_stall = 1'b0;
    logic [5:0] prev_pair = '0;
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(bus.pairValid), 32'd1);
          chk("hold_pair", 32'({bus.pairI, bus.pairJ}), 32'(prev_pair));
        end
        prev_stall = bus.pairValid && !bus.pairReady;
        prev_pair  = {bus.pairI, bus.pairJ};
        if (bus.pairValid && !bus.pairReady) stalls++;
        if (bus.pairValid && bus.pairReady) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_pair: got (%0d,%0d) expected none", bus.pairI, bus.pairJ);
          end else begin
            e = exp_q.pop_front();
            chk("pair", 32'({bus.pairI, bus.pairJ}), 32'(e));
          end
        end
        if (bus.done) begin
          chk("busy_at_done", 32'(bus.busy), 32'd0);
          chk("pairs_left_at_done", 32'(exp_q.size()), 32'd0);
          chk("done_latency", 32'(cyc - start_cyc), 32'(10 + exp_npairs + stalls));
        end
      end
    end
  end

  task automatic run_scan(input logic [24:0] adj, input int mode, input int hold,
                          input bit perturb);
    bit got = 1'b0;
    @(negedge clk);
    rdy_mode  = mode;
    hold_left = hold;
    stalls    = 0;
    exp_q.delete();
    exp_npairs = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 5; j++)
        if (adj[i*5+j]) begin
          exp_q.push_back({3'(i), 3'(j)});
          exp_npairs++;
        end
    start_cyc   = cyc + 1;
    bus.adjFlat = adj;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 300; k++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (perturb) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.adjFlat = 25'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
`ifdef EDGE_SCAN_COUNT_EN
    chk("edge_count", 32'(bus.edgeCount), 32'(exp_npairs));
`endif
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.adjFlat = '0;
    #2;
    chk("rst_valid", 32'(bus.pairValid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Empty matrix, full upper triangle, single held pair, lower/diag only.
    run_scan(25'h0, 0, 0, 1'b0);
    run_scan(upper_mask(), 0, 0, 1'b0);
    chk("all_ones_stalls", 32'(stalls), 32'd0);
    run_scan(25'h0000100, 2, 5, 1'b0);
    chk("held_stalls", 32'(stalls), 32'd5);
    run_scan(25'h1FFFFFF & ~upper_mask(), 0, 0, 1'b0);

    // start and adjFlat wiggled mid-scan must not disturb the captured matrix.
    run_scan(25'h0A5C3E1, 1, 0, 1'b1);

    for (int r = 0; r < 8; r++) run_scan(25'($urandom), 1, 0, 1'b0);

    // Reset while a pair is pending.
    @(negedge clk);
    exp_q.delete();
    rdy_mode    = 3;
    bus.adjFlat = upper_mask();
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 20 && !bus.pairValid; k++) @(negedge clk);
    chk("pending_before_reset", 32'(bus.pairValid), 32'd1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.pairValid), 32'd0);
    chk("async_rst_pair", 32'({bus.pairI, bus.pairJ}), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_done", 32'(bus.done), 32'd0);
`ifdef EDGE_SCAN_COUNT_EN
    chk("async_rst_count", 32'(bus.edgeCount), 32'd0);
`endif
    @(negedge clk);
    rst_n    = 1'b1;
    rdy_mode = 0;
    repeat (3) begin
      @(negedge clk);
      chk("no_replay_valid", 32'(bus.pairValid), 32'd0);
    end
    mon_en = 1'b1;
    run_scan(upper_mask(), 0, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_scan_ctrl.md
EDGE_SCAN_CTRL -- requirements
Module: edge_scan_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit: scan request, sampled only in IDLE.
REQ-004 The block SHALL have the port adjFlat, input, 25 bits: adjacency matrix; bit i*5+j set means edge between vertex i and vertex j.
REQ-005 The block SHALL have the port pairReady, input, 1 bit: the consumer accepts the current pair.
REQ-006 The block SHALL have the port pairValid, output, 1 bit: pairI and pairJ hold a valid edge.
REQ-007 The block SHALL have the port pairI, output, 3 bits: lower vertex index, range 0..3.
REQ-008 The block SHALL have the port pairJ, output, 3 bits: higher vertex index, range 1..4.
REQ-009 The block SHALL have the port busy, output, 1 bit: high in the SCAN and EMIT states.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have the port edgeCount, output, 4 bits: accepted-pair count; this port is present only under the configuration macro (REQ-025).

Function
REQ-012 The FSM SHALL have exactly the states IDLE, SCAN, EMIT and DONE, and all outputs SHALL be registered.
REQ-013 In IDLE, when start=1 at a rising edge, the block SHALL capture adjFlat into an internal register, set the cursor to (0,1), and enter SCAN.
REQ-014 In IDLE, when start=0, the block SHALL remain in IDLE.
REQ-015 The cursor SHALL visit only upper-triangle pairs i<j, in the order (0,1),(0,2),(0,3),(0,4),(1,2),(1,3),(1,4),(2,3),(2,4),(3,4).
REQ-016 Diagonal bits and lower-triangle bits (i>=j) SHALL be ignored.
REQ-017 The block SHALL evaluate one cursor pair per SCAN cycle against the captured matrix: if the bit is clear, it SHALL advance the cursor; if the bit is set, it SHALL load pairI/pairJ, set pairValid=1, and enter EMIT.
REQ-018 In EMIT, pairValid, pairI and pairJ SHALL hold stable until pairValid&&pairReady at a rising edge.
REQ-019 On that EMIT handshake, the block SHALL clear pairValid, advance the cursor and return to SCAN; if the handshake was for pair (3,4), it SHALL enter DONE instead.
REQ-020 Evaluating a clear bit at (3,4) in SCAN SHALL enter DONE.
REQ-021 In DONE, done=1 and busy=0 for exactly one cycle, followed by an unconditional return to IDLE.
REQ-022 start SHALL be ignored in SCAN, EMIT and DONE, and changes to adjFlat after capture SHALL have no effect.
REQ-023 Timing SHALL be as follows, with start sampled at edge N:
- busy SHALL be high from edge N.
- An all-clear scan SHALL reach DONE at edge N+10.
- Each set bit SHALL add 1 + (number of cycles pairReady is low) to that timing.

Reset
REQ-024 With rst_n=0 in any state, including mid-EMIT, the block SHALL immediately and asynchronously enter IDLE with pairValid=0, pairI=0, pairJ=0, busy=0, done=0, cursor=(0,1), captured matrix=0 and edgeCount=0; no pending pair SHALL be replayed after reset release.

Configuration
REQ-025 The macro EDGE_SCAN_COUNT_EN SHALL control edgeCount, as follows:
- When defined, edgeCount SHALL exist, clear to 0 on an accepted start, increment by one per pairValid&&pairReady handshake (max 10, no wrap), and hold its value through DONE and IDLE until the next start.
- When undefined, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 adjFlat=0, start at edge N -> no pairValid, done=1 in the cycle after edge N+10, busy=0 from then on.
REQ-027 Upper triangle all ones, pairReady=1 -> 10 pairs emitted in REQ-015 order, DONE at edge N+20, edgeCount=10 (EDGE_SCAN_COUNT_EN defined).
REQ-028 adjFlat=0x0000100 (only (1,3)), pairReady low for 5 cycles -> pairValid held with pairI=1 and pairJ=3 stable for 5 cycles, a single handshake, then DONE.
REQ-029 Lower triangle and diagonal only, 0x1FFFFFF with the upper-triangle bits cleared -> zero pairs emitted, timing as in REQ-026.
REQ-030 start pulsed during SCAN and adjFlat changed mid-scan -> no restart, and the emitted pairs match the matrix captured at start.
REQ-031 rst_n asserted while in EMIT with pairValid=1 -> all outputs 0 asynchronously; after release, the next start performs a fresh full scan.
